// File: rtl/layer3_fc_argmax.sv
// Final fully-connected layer (64 inputs x 10 classes) with a running argmax.
// One MAC per cycle; the winning class index and score are reported with a one-cycle pulse.
module layer3_fc_argmax #(
    parameter int N_IN  = 64,
    parameter int N_OUT = 10,
    parameter int DW    = 8,
    parameter int BW    = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    output logic [5:0]       x_addr_o,
    output logic             x_en_o,
    input  logic [DW-1:0]    x_data_i,
    output logic [9:0]       w_addr_o,
    output logic             w_en_o,
    input  logic [DW-1:0]    w_data_i,
    output logic [3:0]       b_addr_o,
    output logic             b_en_o,
    input  logic [BW-1:0]    b_data_i,
    output logic             busy_o,
    output logic [3:0]       class_o,
    output logic [ACC_W-1:0] max_score_o,
    output logic             class_valid_o
);

    localparam logic [5:0] K_LAST = 6'(N_IN - 1);
    localparam logic [3:0] N_LAST = 4'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [3:0]               n_q, n_d;
    logic [5:0]               k_q, k_d;
    logic [3:0]               idx_q, idx_d;
    logic signed [ACC_W-1:0]  max_q, max_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     rd_vld_q;
    logic                     first_q;

    logic [5:0]               x_addr_q;
    logic                     x_en_q;
    logic [9:0]               w_addr_q;
    logic                     w_en_q;
    logic [3:0]               b_addr_q;
    logic                     b_en_q;
    logic                     busy_q;
    logic [3:0]               class_q;
    logic [ACC_W-1:0]         max_score_q;
    logic                     class_valid_q;

    logic signed [2*DW-1:0]   prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  bias_ext_s;

    // Sequencer: neuron/input counters, state transitions and argmax update
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        idx_d   = idx_q;
        max_d   = max_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    n_d     = 4'd0;
                    k_d     = 6'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 6'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                // strict compare so a tie keeps the lower class index
                if ((n_q == 4'd0) || (acc_q > max_q)) begin
                    max_d = acc_q;
                    idx_d = n_q;
                end else begin
                    max_d = max_q;
                end
                if (n_q == N_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                    n_d     = n_q + 4'd1;
                    k_d     = 6'd0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // MAC datapath: read data arrives one cycle after the enables
    always_comb begin
        prod_s     = $signed(x_data_i) * $signed(w_data_i);
        prod_ext_s = {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};
        bias_ext_s = {{(ACC_W-BW){b_data_i[BW-1]}}, b_data_i};
        acc_d      = acc_q;
        if (rd_vld_q) begin
            if (first_q) begin
                acc_d = bias_ext_s + prod_ext_s;
            end else begin
                acc_d = acc_q + prod_ext_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // State, counters and accumulator registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            n_q      <= 4'd0;
            k_q      <= 6'd0;
            idx_q    <= 4'd0;
            max_q    <= '0;
            acc_q    <= '0;
            rd_vld_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            k_q      <= k_d;
            idx_q    <= idx_d;
            max_q    <= max_d;
            acc_q    <= acc_d;
            rd_vld_q <= x_en_q;
            first_q  <= b_en_q;
        end
    end

    // Output registers are loaded from next-state values so they line up with the state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x_addr_q      <= 6'd0;
            x_en_q        <= 1'b0;
            w_addr_q      <= 10'd0;
            w_en_q        <= 1'b0;
            b_addr_q      <= 4'd0;
            b_en_q        <= 1'b0;
            busy_q        <= 1'b0;
            class_q       <= 4'd0;
            max_score_q   <= '0;
            class_valid_q <= 1'b0;
        end else begin
            x_en_q        <= (state_d == S_RUN);
            w_en_q        <= (state_d == S_RUN);
            x_addr_q      <= (state_d == S_RUN) ? k_d : 6'd0;
            w_addr_q      <= (state_d == S_RUN) ? {n_d, k_d} : 10'd0;
            b_en_q        <= (state_d == S_RUN) && (k_d == 6'd0);
            b_addr_q      <= ((state_d == S_RUN) && (k_d == 6'd0)) ? n_d : 4'd0;
            busy_q        <= (state_d != S_IDLE);
            class_valid_q <= (state_d == S_DONE);
            if (state_d == S_DONE) begin
                class_q     <= idx_d;
                max_score_q <= max_d;
            end else begin
                class_q     <= class_q;
                max_score_q <= max_score_q;
            end
        end
    end

    assign x_addr_o      = x_addr_q;
    assign x_en_o        = x_en_q;
    assign w_addr_o      = w_addr_q;
    assign w_en_o        = w_en_q;
    assign b_addr_o      = b_addr_q;
    assign b_en_o        = b_en_q;
    assign busy_o        = busy_q;
    assign class_o       = class_q;
    assign max_score_o   = max_score_q;
    assign class_valid_o = class_valid_q;

endmodule

// File: tb/tb_layer3_fc_argmax.sv
// Scoreboard bench for layer3_fc_argmax: ROM models, reference dot-product/argmax model,
// per-cycle address/enable timing checks and a decoupled result monitor.
module tb_layer3_fc_argmax;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic [5:0]  x_addr_o;
    logic        x_en_o;
    logic [7:0]  x_data_i;
    logic [9:0]  w_addr_o;
    logic        w_en_o;
    logic [7:0]  w_data_i;
    logic [3:0]  b_addr_o;
    logic        b_en_o;
    logic [15:0] b_data_i;
    logic        busy_o;
    logic [3:0]  class_o;
    logic [23:0] max_score_o;
    logic        class_valid_o;

    layer3_fc_argmax dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
        .x_addr_o(x_addr_o), .x_en_o(x_en_o), .x_data_i(x_data_i),
        .w_addr_o(w_addr_o), .w_en_o(w_en_o), .w_data_i(w_data_i),
        .b_addr_o(b_addr_o), .b_en_o(b_en_o), .b_data_i(b_data_i),
        .busy_o(busy_o), .class_o(class_o), .max_score_o(max_score_o),
        .class_valid_o(class_valid_o)
    );

    always #5 clk_i = ~clk_i;

    logic signed [7:0]  x_mem [64];
    logic signed [7:0]  w_mem [640];
    logic signed [15:0] b_mem [10];

    typedef struct {
        int          cls;
        logic [23:0] score;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Synchronous-read memories: data appears the cycle after the enable
    always @(posedge clk_i) begin
        if (x_en_o) x_data_i <= x_mem[x_addr_o];
        if (w_en_o) w_data_i <= w_mem[w_addr_o];
        if (b_en_o) b_data_i <= b_mem[b_addr_o];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fill the three memories for a directed pattern (0 = fully random)
    task automatic set_job(input int kind);
        for (int k = 0; k < 64; k++) x_mem[k] = 8'($urandom);
        for (int a = 0; a < 640; a++) w_mem[a] = 8'($urandom);
        for (int n = 0; n < 10; n++) b_mem[n] = 16'($urandom);
        case (kind)
            1: begin
                for (int a = 0; a < 640; a++) w_mem[a] = 8'sd0;
                for (int n = 0; n < 10; n++) b_mem[n] = 16'(n);
            end
            2: begin
                for (int a = 0; a < 640; a++) w_mem[a] = 8'sd0;
                for (int n = 0; n < 10; n++) b_mem[n] = 16'sd5;
            end
            3: begin
                for (int k = 0; k < 64; k++) x_mem[k] = 8'sd1;
                for (int a = 0; a < 640; a++) w_mem[a] = (a / 64 == 4) ? 8'sd2 : -8'sd1;
                for (int n = 0; n < 10; n++) b_mem[n] = 16'sd0;
            end
            4: begin
                for (int a = 0; a < 640; a++) w_mem[a] = 8'sd0;
                for (int n = 0; n < 10; n++) b_mem[n] = (n == 3) ? -16'sd1 : -16'sd100;
            end
            5: begin
                for (int k = 0; k < 64; k++) x_mem[k] = -8'sd128;
                for (int a = 0; a < 640; a++) w_mem[a] = (a / 64 == 7) ? -8'sd128 : 8'sd0;
                for (int n = 0; n < 10; n++) b_mem[n] = 16'sd0;
            end
            default: begin
                x_mem[0] = x_mem[0];
            end
        endcase
    endtask

    // Reference: each score is bias + dot product; first strictly greater score wins
    task automatic start_job();
        exp_t e;
        int best_s;
        int best_n;
        int s;
        best_s = 0;
        best_n = 0;
        for (int n = 0; n < 10; n++) begin
            s = int'(b_mem[n]);
            for (int k = 0; k < 64; k++) s += int'(x_mem[k]) * int'(w_mem[n * 64 + k]);
            if (n == 0 || s > best_s) begin
                best_s = s;
                best_n = n;
            end
        end
        @(negedge clk_i);
        check("idle_before_start", {63'd0, busy_o}, 64'd0);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        e.cls   = best_n;
        e.score = best_s[23:0];
        e.cyc   = cyc + 660;
        sb_q.push_back(e);
        check("busy_after_start", {63'd0, busy_o}, 64'd1);
    endtask

    // Walk cycles 1..661 of a run checking the read sweep; optionally pulse start_i
    task automatic track_job(input int p1, input int p2);
        int n;
        int j;
        logic        e_run;
        logic        e_b;
        logic [22:0] act;
        logic [22:0] exp;
        for (int i = 1; i <= 661; i++) begin
            @(negedge clk_i);
            start_i = (i == p1) || (i == p2);
            n = (i - 1) / 66;
            j = (i - 1) % 66;
            e_run = (i <= 660) && (j < 64);
            e_b   = e_run && (j == 0);
            exp = {1'b1, e_run, e_run, e_b,
                   e_run ? 6'(j) : 6'd0, e_run ? 10'(n * 64 + j) : 10'd0, e_b ? 4'(n) : 4'd0};
            act = {busy_o, x_en_o, w_en_o, b_en_o,
                   e_run ? x_addr_o : 6'd0, e_run ? w_addr_o : 10'd0, e_b ? b_addr_o : 4'd0};
            check($sformatf("sweep_cycle_%0d", i), {41'd0, act}, {41'd0, exp});
        end
    endtask

    // Result monitor: pops an expectation whenever a pulse is seen
    logic prev_v = 1'b0;
    int   held_cls = 0;
    always @(negedge clk_i) begin
        exp_t e;
        if (!rstn_i) begin
            prev_v <= 1'b0;
        end else begin
            if (prev_v) begin
                check("pulse_width", {63'd0, class_valid_o}, 64'd0);
                check("class_hold", {60'd0, class_o}, 64'(held_cls));
            end
            if (class_valid_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {63'd0, class_valid_o}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("class", {60'd0, class_o}, 64'(e.cls));
                    check("max_score", {40'd0, max_score_o}, {40'd0, e.score});
                    check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                    check("busy_at_pulse", {63'd0, busy_o}, 64'd1);
                    held_cls <= e.cls;
                end
            end
            prev_v <= class_valid_o;
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {x_addr_o, x_en_o, w_addr_o, w_en_o, b_addr_o, b_en_o, busy_o,
                     class_o, max_score_o, class_valid_o}, 64'd0);
    endtask

    initial begin
        rstn_i   = 1'b0;
        start_i  = 1'b0;
        x_data_i = 8'd0;
        w_data_i = 8'd0;
        b_data_i = 16'd0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset_state");
        rstn_i = 1'b1;

        for (int t = 1; t <= 5; t++) begin
            set_job(t);
            start_job();
            track_job(0, 0);
        end

        // ignored start pulses mid-run and in the DONE cycle
        set_job(0);
        start_job();
        track_job(100, 661);
        @(negedge clk_i);
        start_i = 1'b0;
        check("no_restart_busy", {63'd0, busy_o}, 64'd0);

        // reset in cycle 300 aborts the run
        set_job(0);
        start_job();
        repeat (299) @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        check_all_zero("abort_outputs");
        sb_q.delete();
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (700) @(negedge clk_i);
        check("abort_idle", {62'd0, busy_o, class_valid_o}, 64'd0);

        // back-to-back random jobs, each started in the cycle right after DONE
        for (int r = 0; r < 4; r++) begin
            set_job(0);
            start_job();
            track_job(0, 0);
        end
        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
